hls_pp_loop_activity_monitor: RTL and testbench

- Synthesizable RTL monitor for one HLS-generated block containing one pipelined loop (e.g. spmv_Pipeline_L2).
- Watches the block-level ap_start/ap_ready/ap_done/ap_continue handshake, the one-hot FSM state and the pipeline enable/block flags.
- Produces live status and saturating counters: transactions, loop invocations, iterations started/completed, in-flight iterations, stall cycles.
- Sits beside the DUT in simulation or emulation; passive: it never drives the watched block.

---
 rtl/hls_mon_pkg.sv | 26 ++
 rtl/sat_counter.sv | 26 ++
 rtl/hls_pp_loop_activity_monitor.sv | 183 ++++++++++++++++++
 tb/tb_hls_pp_loop_activity_monitor.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hls_mon_pkg.sv
// Shared types and helpers for the HLS pipelined-loop activity monitor.
// Helpers work on a fixed wide vector; callers zero-extend narrower operands.
package hls_mon_pkg;

  localparam int CNT_W_DEF = 32;
  localparam int WIDE_W    = 64;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } loop_state_e;

  // Increment that sticks at the all-ones value of a w-bit counter.
  function automatic logic [WIDE_W-1:0] sat_inc(input logic [WIDE_W-1:0] v,
                                                input int unsigned w);
    logic [WIDE_W-1:0] max_v;
    max_v = (w >= WIDE_W) ? '1 : ((WIDE_W'(1) << w) - WIDE_W'(1));
    return (v >= max_v) ? max_v : v + WIDE_W'(1);
  endfunction

  function automatic logic onehot_hit(input logic [WIDE_W-1:0] s,
                                      input logic [WIDE_W-1:0] x);
    return |(s & x);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear and a hold (freeze) input.
module sat_counter
  import hls_mon_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         freeze,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [WIDE_W-1:0] next_wide;

  always_comb next_wide = sat_inc(WIDE_W'(count), W);

  always_ff @(posedge clock) begin
    if (clear) begin
      count <= '0;
    end else if (!freeze && inc) begin
      count <= next_wide[W-1:0];
    end
  end

endmodule

// File: rtl/hls_pp_loop_activity_monitor.sv
// Passive monitor for an HLS block with one pipelined loop: handshake tracking,
// loop entry/exit FSM, iteration/stall counters, and a finish-triggered freeze.
module hls_pp_loop_activity_monitor
  import hls_mon_pkg::*;
#(
  parameter int STATE_W = 50,
  parameter int N_POST  = 8,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ap_start,
  input  logic                      ap_ready,
  input  logic                      ap_done,
  input  logic                      ap_continue,
  input  logic                      finish,
  input  logic [STATE_W-1:0]        cur_state,
  input  logic [STATE_W-1:0]        pre_loop_state,
  input  logic [N_POST*STATE_W-1:0] post_loop_state,
  input  logic [N_POST-1:0]         post_states_valid,
  input  logic [STATE_W-1:0]        iter_start_state,
  input  logic                      iter_start_enable,
  input  logic                      iter_start_block,
  input  logic [STATE_W-1:0]        iter_end_state,
  input  logic                      iter_end_enable,
  input  logic                      iter_end_block,
  input  logic [STATE_W-1:0]        loop_quit_state,
  input  logic                      quit_at_end,
  output logic                      mod_busy,
  output logic                      loop_active,
  output logic [CNT_W-1:0]          trans_cnt,
  output logic [CNT_W-1:0]          done_cnt,
  output logic [CNT_W-1:0]          busy_cycles,
  output logic [CNT_W-1:0]          loop_cnt,
  output logic [CNT_W-1:0]          iter_start_cnt,
  output logic [CNT_W-1:0]          iter_end_cnt,
  output logic [CNT_W-1:0]          in_flight,
  output logic [CNT_W-1:0]          stall_cycles,
  output logic                      frozen,
  output logic                      dump_valid
);

  logic [STATE_W-1:0] prev_state;
  loop_state_e        state_q, state_d;
  logic               dump_done;

  logic ready_seen;
  logic start_ev, done_ev;
  logic in_start, in_end, was_pre, was_quit, post_hit;
  logic entry_ev, exit_ev;
  logic iter_start_ev, iter_end_ev, stall_ev;
  logic [STATE_W-1:0] quit_sel;

  // ap_ready only qualifies the handshake; it never feeds a counter.
  assign ready_seen = ap_ready;

  // A done while busy frees the slot, so a start in that same cycle is a
  // back-to-back transaction rather than a start that is ignored.
  assign done_ev  = ap_done & ap_continue & mod_busy;
  assign start_ev = ap_start & (~mod_busy | done_ev);

  assign quit_sel = quit_at_end ? iter_end_state : loop_quit_state;
  assign in_start = onehot_hit(WIDE_W'(cur_state), WIDE_W'(iter_start_state));
  assign in_end   = onehot_hit(WIDE_W'(cur_state), WIDE_W'(iter_end_state));
  assign was_pre  = onehot_hit(WIDE_W'(prev_state), WIDE_W'(pre_loop_state));
  assign was_quit = onehot_hit(WIDE_W'(prev_state), WIDE_W'(quit_sel));

  always_comb begin
    post_hit = 1'b0;
    for (int k = 0; k < N_POST; k++) begin
      if (post_states_valid[k] &&
          onehot_hit(WIDE_W'(cur_state),
                     WIDE_W'(post_loop_state[k*STATE_W +: STATE_W]))) begin
        post_hit = 1'b1;
      end
    end
  end

  // Entry is only legal from IDLE and exit only from RUN, so a cycle that
  // qualifies for both while running resolves as an exit.
  always_comb begin
    state_d  = state_q;
    entry_ev = 1'b0;
    exit_ev  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_start && was_pre) begin
          state_d  = RUN;
          entry_ev = 1'b1;
        end
      end
      RUN: begin
        if (was_quit && post_hit) begin
          state_d = IDLE;
          exit_ev = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign loop_active   = (state_q == RUN);
  assign iter_start_ev = loop_active & in_start & iter_start_enable & ~iter_start_block;
  assign iter_end_ev   = loop_active & in_end & iter_end_enable & ~iter_end_block;
  assign stall_ev      = loop_active & (iter_start_block | iter_end_block);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      prev_state <= '0;
      mod_busy   <= 1'b0;
    end else if (!frozen) begin
      state_q    <= state_d;
      prev_state <= cur_state;
      if (start_ev) begin
        mod_busy <= 1'b1;
      end else if (done_ev) begin
        mod_busy <= 1'b0;
      end
    end
  end

  // Balance of issued vs retired iterations, floored at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_flight <= '0;
    end else if (!frozen) begin
      if (iter_start_ev && !iter_end_ev) begin
        if (!(&in_flight)) begin
          in_flight <= in_flight + CNT_W'(1);
        end
      end else if (!iter_start_ev && iter_end_ev && (in_flight != '0)) begin
        in_flight <= in_flight - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      frozen     <= 1'b0;
      dump_valid <= 1'b0;
      dump_done  <= 1'b0;
    end else begin
      if (finish) begin
        frozen <= 1'b1;
      end
      dump_valid <= frozen & ~dump_done;
      dump_done  <= dump_done | frozen;
    end
  end

  sat_counter #(.W(CNT_W)) u_trans_cnt (
    .clock(clock), .clear(reset), .freeze(frozen), .inc(start_ev), .count(trans_cnt)
  );

  sat_counter #(.W(CNT_W)) u_done_cnt (
    .clock(clock), .clear(reset), .freeze(frozen), .inc(done_ev), .count(done_cnt)
  );

  sat_counter #(.W(CNT_W)) u_busy_cycles (
    .clock(clock), .clear(reset), .freeze(frozen), .inc(mod_busy), .count(busy_cycles)
  );

  sat_counter #(.W(CNT_W)) u_loop_cnt (
    .clock(clock), .clear(reset), .freeze(frozen), .inc(entry_ev), .count(loop_cnt)
  );

  sat_counter #(.W(CNT_W)) u_iter_start_cnt (
    .clock(clock), .clear(reset), .freeze(frozen), .inc(iter_start_ev), .count(iter_start_cnt)
  );

  sat_counter #(.W(CNT_W)) u_iter_end_cnt (
    .clock(clock), .clear(reset), .freeze(frozen), .inc(iter_end_ev), .count(iter_end_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cycles (
    .clock(clock), .clear(reset), .freeze(frozen), .inc(stall_ev), .count(stall_cycles)
  );

  logic unused_ok;
  assign unused_ok = ready_seen ^ exit_ev;

endmodule

// File: tb/tb_hls_pp_loop_activity_monitor.sv
// Directed bench: drives handshake and FSM-state traffic, pushes expected output
// snapshots to a queue and pops them against the monitor's registered outputs.
module tb_hls_pp_loop_activity_monitor;

  localparam int SW    = 50;
  localparam int NP    = 8;
  localparam int CW    = 32;
  localparam int SNAP_W = 4 + 8*CW;

  localparam logic [SW-1:0] ST_IDLE = SW'(1) << 0;
  localparam logic [SW-1:0] ST_PRE  = SW'(1) << 2;
  localparam logic [SW-1:0] ST_IT0  = SW'(1) << 5;
  localparam logic [SW-1:0] ST_IT1  = SW'(1) << 6;
  localparam logic [SW-1:0] ST_QUIT = SW'(1) << 7;
  localparam logic [SW-1:0] ST_POST3 = SW'(1) << 13;
  localparam logic [SW-1:0] ST_POST5 = SW'(1) << 15;

  logic clock, reset;
  logic ap_start, ap_ready, ap_done, ap_continue, finish;
  logic [SW-1:0] cur_state, pre_loop_state, iter_start_state, iter_end_state, loop_quit_state;
  logic [NP*SW-1:0] post_loop_state;
  logic [NP-1:0] post_states_valid;
  logic iter_start_enable, iter_start_block, iter_end_enable, iter_end_block, quit_at_end;

  logic mod_busy, loop_active, frozen, dump_valid;
  logic [CW-1:0] trans_cnt, done_cnt, busy_cycles, loop_cnt;
  logic [CW-1:0] iter_start_cnt, iter_end_cnt, in_flight, stall_cycles;

  logic s_mod_busy, s_loop_active, s_frozen, s_dump_valid;
  logic [2:0] s_trans_cnt, s_done_cnt, s_busy_cycles, s_loop_cnt;
  logic [2:0] s_iter_start_cnt, s_iter_end_cnt, s_in_flight, s_stall_cycles;

  hls_pp_loop_activity_monitor #(.STATE_W(SW), .N_POST(NP), .CNT_W(CW)) u_dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
    .cur_state(cur_state), .pre_loop_state(pre_loop_state),
    .post_loop_state(post_loop_state), .post_states_valid(post_states_valid),
    .iter_start_state(iter_start_state), .iter_start_enable(iter_start_enable),
    .iter_start_block(iter_start_block), .iter_end_state(iter_end_state),
    .iter_end_enable(iter_end_enable), .iter_end_block(iter_end_block),
    .loop_quit_state(loop_quit_state), .quit_at_end(quit_at_end),
    .mod_busy(mod_busy), .loop_active(loop_active), .trans_cnt(trans_cnt),
    .done_cnt(done_cnt), .busy_cycles(busy_cycles), .loop_cnt(loop_cnt),
    .iter_start_cnt(iter_start_cnt), .iter_end_cnt(iter_end_cnt),
    .in_flight(in_flight), .stall_cycles(stall_cycles), .frozen(frozen),
    .dump_valid(dump_valid)
  );

  // Narrow-counter copy on the same inputs, used to observe saturation.
  hls_pp_loop_activity_monitor #(.STATE_W(SW), .N_POST(NP), .CNT_W(3)) u_dut_sat (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
    .cur_state(cur_state), .pre_loop_state(pre_loop_state),
    .post_loop_state(post_loop_state), .post_states_valid(post_states_valid),
    .iter_start_state(iter_start_state), .iter_start_enable(iter_start_enable),
    .iter_start_block(iter_start_block), .iter_end_state(iter_end_state),
    .iter_end_enable(iter_end_enable), .iter_end_block(iter_end_block),
    .loop_quit_state(loop_quit_state), .quit_at_end(quit_at_end),
    .mod_busy(s_mod_busy), .loop_active(s_loop_active), .trans_cnt(s_trans_cnt),
    .done_cnt(s_done_cnt), .busy_cycles(s_busy_cycles), .loop_cnt(s_loop_cnt),
    .iter_start_cnt(s_iter_start_cnt), .iter_end_cnt(s_iter_end_cnt),
    .in_flight(s_in_flight), .stall_cycles(s_stall_cycles), .frozen(s_frozen),
    .dump_valid(s_dump_valid)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard state
  logic [SNAP_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  logic e_busy, e_active, e_frozen, e_dump;
  logic [CW-1:0] e_trans, e_done, e_bcyc, e_loop, e_is, e_ie, e_inf, e_stall;

  task automatic check_val(input string tag, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    e_busy = 0; e_active = 0; e_frozen = 0; e_dump = 0;
    e_trans = 0; e_done = 0; e_bcyc = 0; e_loop = 0;
    e_is = 0; e_ie = 0; e_inf = 0; e_stall = 0;
  endtask

  task automatic push_exp();
    exp_q.push_back({e_busy, e_active, e_frozen, e_dump, e_trans, e_done, e_bcyc,
                     e_loop, e_is, e_ie, e_inf, e_stall});
  endtask

  task automatic check_outputs(input string tag);
    logic [SNAP_W-1:0] s;
    if (exp_q.size() == 0) begin
      check_val({tag, "_queue_empty"}, 1, 0);
      return;
    end
    s = exp_q.pop_front();
    check_val({tag, "_mod_busy"},     CW'(mod_busy),    CW'(s[SNAP_W-1]));
    check_val({tag, "_loop_active"},  CW'(loop_active), CW'(s[SNAP_W-2]));
    check_val({tag, "_frozen"},       CW'(frozen),      CW'(s[SNAP_W-3]));
    check_val({tag, "_dump_valid"},   CW'(dump_valid),  CW'(s[SNAP_W-4]));
    check_val({tag, "_trans_cnt"},    trans_cnt,        s[7*CW +: CW]);
    check_val({tag, "_done_cnt"},     done_cnt,         s[6*CW +: CW]);
    check_val({tag, "_busy_cycles"},  busy_cycles,      s[5*CW +: CW]);
    check_val({tag, "_loop_cnt"},     loop_cnt,         s[4*CW +: CW]);
    check_val({tag, "_iter_start"},   iter_start_cnt,   s[3*CW +: CW]);
    check_val({tag, "_iter_end"},     iter_end_cnt,     s[2*CW +: CW]);
    check_val({tag, "_in_flight"},    in_flight,        s[1*CW +: CW]);
    check_val({tag, "_stall_cycles"}, stall_cycles,     s[0 +: CW]);
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [SW-1:0] cs, input logic se, input logic sb,
                       input logic ee, input logic eb);
    cur_state = cs;
    iter_start_enable = se; iter_start_block = sb;
    iter_end_enable = ee;   iter_end_block = eb;
    tick();
  endtask

  initial begin
    reset = 1; ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 1; finish = 0;
    cur_state = ST_IDLE; pre_loop_state = ST_PRE; iter_start_state = ST_IT0;
    iter_end_state = ST_IT1; loop_quit_state = ST_QUIT; quit_at_end = 0;
    iter_start_enable = 0; iter_start_block = 0; iter_end_enable = 0; iter_end_block = 0;
    post_states_valid = 8'b1101_1111;
    for (int k = 0; k < NP; k++) post_loop_state[k*SW +: SW] = SW'(1) << (10 + k);
    model_clear();

    repeat (3) tick();
    push_exp(); check_outputs("reset");
    reset = 0;

    // Single transaction: start, then done eight cycles later
    ap_start = 1; tick(); ap_start = 0;
    e_busy = 1; e_trans = 1;
    push_exp(); check_outputs("txn_start");
    repeat (7) tick();
    ap_done = 1; ap_ready = 1; tick(); ap_done = 0; ap_ready = 0;
    e_busy = 0; e_done = 1; e_bcyc = 8;
    push_exp(); check_outputs("txn_done");
    check_val("sat_busy_cycles", CW'(s_busy_cycles), 7);

    // Back-to-back: start coincides with the done of the running transaction
    ap_start = 1; tick(); ap_start = 0;
    tick();
    ap_start = 1; ap_done = 1; tick(); ap_start = 0;
    e_busy = 1; e_trans = 3; e_done = 2; e_bcyc = 10;
    push_exp(); check_outputs("b2b");
    tick(); ap_done = 0;
    e_busy = 0; e_done = 3; e_bcyc = 11;
    push_exp(); check_outputs("b2b_done");
    check_val("sat_trans_cnt", CW'(s_trans_cnt), 3);

    // Loop with 5 issues, 5 retires, exit via quit state into post slice 3
    drive(ST_PRE, 0, 0, 0, 0);
    drive(ST_IT0, 0, 0, 0, 0);
    e_active = 1; e_loop = 1;
    repeat (5) drive(ST_IT0, 1, 0, 0, 0);
    e_is = 5; e_inf = 5;
    push_exp(); check_outputs("loop_issue");
    repeat (5) drive(ST_IT1, 0, 0, 1, 0);
    e_ie = 5; e_inf = 0;
    drive(ST_QUIT, 0, 0, 0, 0);
    drive(ST_POST3, 0, 0, 0, 0);
    e_active = 0;
    push_exp(); check_outputs("loop_exit");

    // Re-entry, same-cycle start/end, stall, retire past zero
    drive(ST_PRE, 0, 0, 0, 0);
    drive(ST_IT0, 0, 0, 0, 0);
    e_active = 1; e_loop = 2;
    repeat (2) drive(ST_IT0, 1, 0, 0, 0);
    e_is = 7; e_inf = 2;
    iter_end_state = ST_IT0;
    repeat (3) drive(ST_IT0, 1, 0, 1, 0);
    e_is = 10; e_ie = 8;
    push_exp(); check_outputs("same_cycle");
    repeat (4) drive(ST_IT0, 1, 1, 0, 0);
    e_stall = 4;
    push_exp(); check_outputs("stall");
    repeat (3) drive(ST_IT0, 0, 0, 1, 0);
    e_ie = 11; e_inf = 0;
    push_exp(); check_outputs("underflow");
    iter_end_state = ST_IT1;

    // Exit into an invalid post slice is ignored; quit_at_end exit works
    drive(ST_QUIT, 0, 0, 0, 0);
    drive(ST_POST5, 0, 0, 0, 0);
    push_exp(); check_outputs("invalid_post");
    quit_at_end = 1;
    drive(ST_IT1, 0, 0, 0, 0);
    drive(ST_POST3, 0, 0, 0, 0);
    e_active = 0;
    push_exp(); check_outputs("quit_at_end");
    quit_at_end = 0;
    drive(ST_IT0, 0, 0, 0, 0);
    push_exp(); check_outputs("no_reentry");

    // finish mid-loop freezes everything; dump_valid pulses once
    drive(ST_PRE, 0, 0, 0, 0);
    drive(ST_IT0, 0, 0, 0, 0);
    e_active = 1; e_loop = 3;
    drive(ST_IT0, 1, 0, 0, 0);
    e_is = 11; e_inf = 1;
    finish = 1;
    drive(ST_IT0, 1, 0, 0, 0);
    finish = 0;
    e_is = 12; e_inf = 2; e_frozen = 1;
    push_exp(); check_outputs("freeze");
    ap_start = 1;
    drive(ST_IT0, 1, 0, 1, 0);
    ap_start = 0;
    e_dump = 1;
    push_exp(); check_outputs("dump_pulse");
    drive(ST_IT0, 1, 1, 0, 0);
    e_dump = 0;
    push_exp(); check_outputs("frozen_hold");
    drive(ST_QUIT, 0, 0, 0, 0);
    push_exp(); check_outputs("frozen_hold2");

    // Reset clears everything, including frozen
    reset = 1;
    drive(ST_IT0, 0, 0, 0, 0);
    model_clear();
    push_exp(); check_outputs("post_reset");
    check_val("sat_busy_reset", CW'(s_busy_cycles), 0);
    reset = 0;
    drive(ST_IDLE, 0, 0, 0, 0);
    push_exp(); check_outputs("after_reset");

    check_val("queue_drained", CW'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
